// File: rtl/flash_audio_pkg.sv
// Shared types and default region constants for the flash audio address controller.
package flash_audio_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } transport_state_t;

    localparam int          ADDR_W_DEF     = 23;
    localparam logic [22:0] START_ADDR_DEF = 23'h000000;
    localparam logic [22:0] END_ADDR_DEF   = 23'h07FFFF;

endpackage

// File: rtl/flash_audio_address_ctrl_updown_bound_counter.sv
// Combinational +/-1 step with bound detection; a crossing yields the opposite bound
// as next, and the owner decides whether to take it (wrap) or hold.
module updown_bound_counter #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = '1
) (
    input  logic [ADDR_W-1:0] cur,
    input  logic              up,
    input  logic              dn,
    output logic [ADDR_W-1:0] next,
    output logic              at_bound
);

    logic cross_up;
    logic cross_dn;

    assign cross_up = up && (cur == END_ADDR);
    assign cross_dn = dn && (cur == START_ADDR);
    assign at_bound = cross_up || cross_dn;

    // The bound +/- 1 value is never produced: crossings map straight to the opposite bound.
    always_comb begin
        next = cur;
        if (cross_up)      next = START_ADDR;
        else if (cross_dn) next = END_ADDR;
        else if (up)       next = cur + 1'b1;
        else if (dn)       next = cur - 1'b1;
    end

endmodule

// File: rtl/flash_audio_address_ctrl.sv
// Playback transport FSM and flash word address register.
// Define FLASH_AUDIO_LOOP_EN to wrap at region bounds instead of stopping in DONE.
module flash_audio_address_ctrl
    import flash_audio_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_ADDR_DEF),
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(END_ADDR_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              address_inc,
    input  logic              address_dec,
    input  logic              address_rst,
    input  logic              cmd_play,
    input  logic              cmd_pause,
    input  logic              cmd_restart,
    input  logic              dir_reverse,
    output logic [ADDR_W-1:0] flsh_address,
    output logic              playing,
    output logic              wrapped,
    output logic              done,
    output transport_state_t  state
);

`ifdef FLASH_AUDIO_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic              fwd;
    logic              up;
    logic              dn;
    logic              at_bound;
    logic [ADDR_W-1:0] next;
    logic [ADDR_W-1:0] start_pos;

    // Requests are relative to the playback direction; inc and dec together cancel.
    assign fwd       = !dir_reverse;
    assign start_pos = fwd ? START_ADDR : END_ADDR;
    assign up        = (address_inc ^ address_dec) && (address_inc ? fwd : !fwd);
    assign dn        = (address_inc ^ address_dec) && (address_inc ? !fwd : fwd);

    updown_bound_counter #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR)
    ) u_counter (
        .cur      (flsh_address),
        .up       (up),
        .dn       (dn),
        .next     (next),
        .at_bound (at_bound)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_STOP;
            flsh_address <= START_ADDR;
            wrapped      <= 1'b0;
        end else begin
            wrapped <= 1'b0;
            if (cmd_restart) begin
                state        <= ST_PLAY;
                flsh_address <= start_pos;
            end else begin
                case (state)
                    ST_STOP: begin
                        if (!cmd_pause && cmd_play) state <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        if (address_rst) begin
                            flsh_address <= start_pos;
                        end else if (at_bound) begin
                            wrapped <= 1'b1;
                            if (LOOP_EN) flsh_address <= next;
                        end else begin
                            flsh_address <= next;
                        end
                        if (cmd_pause)
                            state <= ST_PAUSE;
                        else if (!address_rst && at_bound && !LOOP_EN)
                            state <= ST_DONE;
                    end
                    ST_PAUSE: begin
                        if (address_rst) flsh_address <= start_pos;
                        if (!cmd_pause && cmd_play) state <= ST_PLAY;
                    end
                    ST_DONE: begin
                        if (!cmd_pause && cmd_play) begin
                            state        <= ST_PLAY;
                            flsh_address <= start_pos;
                        end else if (address_rst) begin
                            flsh_address <= start_pos;
                        end
                    end
                    default: state <= ST_STOP;
                endcase
            end
        end
    end

    assign playing = (state == ST_PLAY);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_flash_audio_address_ctrl.sv
// Directed bench for flash_audio_address_ctrl; expectations follow FLASH_AUDIO_LOOP_EN.
module tb_flash_audio_address_ctrl;
    import flash_audio_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             address_inc, address_dec, address_rst;
    logic             cmd_play, cmd_pause, cmd_restart;
    logic             dir_reverse;
    logic [22:0]      flsh_address;
    logic             playing, wrapped, done;
    transport_state_t state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flash_audio_address_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .address_inc  (address_inc),
        .address_dec  (address_dec),
        .address_rst  (address_rst),
        .cmd_play     (cmd_play),
        .cmd_pause    (cmd_pause),
        .cmd_restart  (cmd_restart),
        .dir_reverse  (dir_reverse),
        .flsh_address (flsh_address),
        .playing      (playing),
        .wrapped      (wrapped),
        .done         (done),
        .state        (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of pulses, sample 1 time unit after the edge, then release.
    task automatic pulse(input logic inc, input logic dec, input logic arst,
                         input logic play, input logic pause, input logic restart);
        address_inc = inc;  address_dec = dec;  address_rst = arst;
        cmd_play    = play; cmd_pause   = pause; cmd_restart = restart;
        @(posedge clk);
        #1;
        address_inc = 0; address_dec = 0; address_rst = 0;
        cmd_play    = 0; cmd_pause   = 0; cmd_restart = 0;
    endtask

    initial begin
        rst = 0; dir_reverse = 0;
        address_inc = 0; address_dec = 0; address_rst = 0;
        cmd_play = 0; cmd_pause = 0; cmd_restart = 0;

        // Reset and gating in STOP
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", 32'(flsh_address), 32'h0);
        check("rst_playing", 32'(playing), 32'h0);
        check("rst_wrapped", 32'(wrapped), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_state", 32'(state), 32'(ST_STOP));
        rst = 1;
        pulse(1, 0, 0, 0, 0, 0);
        check("stop_inc_addr", 32'(flsh_address), 32'h0);
        check("stop_inc_playing", 32'(playing), 32'h0);

        // Forward stepping
        pulse(0, 0, 0, 1, 0, 0);
        check("play_playing", 32'(playing), 32'h1);
        check("play_addr", 32'(flsh_address), 32'h0);
        pulse(1, 0, 0, 0, 0, 0);
        check("fwd_step1", 32'(flsh_address), 32'h1);
        pulse(1, 0, 0, 0, 0, 0);
        check("fwd_step2", 32'(flsh_address), 32'h2);
        pulse(1, 0, 0, 0, 0, 0);
        check("fwd_step3", 32'(flsh_address), 32'h3);

        // Back to the start, then a reverse step at address 0
        pulse(0, 0, 1, 0, 0, 0);
        check("arst_addr", 32'(flsh_address), 32'h0);
        dir_reverse = 1;
        pulse(1, 0, 0, 0, 0, 0);
`ifdef FLASH_AUDIO_LOOP_EN
        check("rev_wrap_addr", 32'(flsh_address), 32'h7FFFF);
        check("rev_wrap_pulse", 32'(wrapped), 32'h1);
        check("rev_wrap_playing", 32'(playing), 32'h1);
        check("rev_wrap_done", 32'(done), 32'h0);
`else
        check("rev_hold_addr", 32'(flsh_address), 32'h0);
        check("rev_hold_wrapped", 32'(wrapped), 32'h1);
        check("rev_hold_done", 32'(done), 32'h1);
        check("rev_hold_playing", 32'(playing), 32'h0);
`endif
        pulse(0, 0, 0, 0, 0, 0);
        check("wrapped_one_cycle", 32'(wrapped), 32'h0);

        // Restart forward from either DONE or PLAY
        dir_reverse = 0;
        pulse(0, 0, 0, 0, 0, 1);
        check("restart_fwd_addr", 32'(flsh_address), 32'h0);
        check("restart_fwd_state", 32'(state), 32'(ST_PLAY));

        // Simultaneous requests
        pulse(1, 0, 0, 0, 0, 0);
        pulse(1, 0, 0, 0, 0, 0);
        check("pre_both_addr", 32'(flsh_address), 32'h2);
        pulse(1, 1, 0, 0, 0, 0);
        check("inc_dec_cancel", 32'(flsh_address), 32'h2);
        repeat (3) pulse(1, 0, 0, 0, 0, 0);
        check("at_five", 32'(flsh_address), 32'h5);
        pulse(1, 0, 1, 0, 0, 0);
        check("arst_over_inc", 32'(flsh_address), 32'h0);

        // Pause freezes stepping
        pulse(1, 0, 0, 0, 0, 0);
        check("pre_pause_addr", 32'(flsh_address), 32'h1);
        pulse(0, 0, 0, 0, 1, 0);
        check("pause_state", 32'(state), 32'(ST_PAUSE));
        check("pause_playing", 32'(playing), 32'h0);
        repeat (4) pulse(1, 0, 0, 0, 0, 0);
        check("pause_frozen", 32'(flsh_address), 32'h1);
        pulse(0, 0, 0, 1, 0, 0);
        check("resume_playing", 32'(playing), 32'h1);
        pulse(1, 0, 0, 0, 0, 0);
        check("resume_step", 32'(flsh_address), 32'h2);
        pulse(0, 1, 0, 0, 0, 0);
        check("fwd_dec", 32'(flsh_address), 32'h1);

        // Back-to-back steps on consecutive cycles up to 0x100
        address_inc = 1;
        repeat (255) @(posedge clk);
        #1;
        address_inc = 0;
        check("b2b_addr", 32'(flsh_address), 32'h100);

        // Reverse restart and reset overriding a command
        dir_reverse = 1;
        pulse(0, 0, 0, 0, 0, 1);
        check("restart_rev_addr", 32'(flsh_address), 32'h7FFFF);
        check("restart_rev_state", 32'(state), 32'(ST_PLAY));
        rst = 0;
        pulse(0, 0, 0, 1, 0, 0);
        check("midrst_state", 32'(state), 32'(ST_STOP));
        check("midrst_addr", 32'(flsh_address), 32'h0);
        check("midrst_playing", 32'(playing), 32'h0);
        rst = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
